rgb_pwm_driver: RTL
===================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter: PRESCALE, default 4, clk cycles per PWM step (legal 1..65535).
REQ-002 Parameter: STEPS, default 255, PWM steps per period; fixed for 8-bit duty.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 colour_in  input  24  colour from the upstream selector; [23:16]=R, [15:8]=G, [7:0]=B.
REQ-006 colour_valid  input  1  colour_in offered this cycle.
REQ-007 colour_ready  output  1  pending slot empty; transfer on valid&ready.
REQ-008 sys_on  input  1  run enable; low forces IDLE.
REQ-009 pwm_r, pwm_g, pwm_b  output  1 each  registered PWM drive for the LED channels.
REQ-010 period_done  output  1  one-cycle pulse at each period wrap.

Function
REQ-011 Two states, IDLE and RUN: IDLE->RUN when sys_on=1; RUN->IDLE on the first cycle sys_on=0.
REQ-012 Prescaler pre_cnt counts 0..PRESCALE-1 in RUN; step tick asserts when pre_cnt=PRESCALE-1, then pre_cnt wraps to 0.
REQ-013 Step counter step_cnt (8-bit) advances on tick, 0..254, wraps 254->0; never reaches 255.
REQ-014 period_done pulses high for exactly one cycle, the cycle after the tick on which step_cnt wraps 254->0.
REQ-015 Pending register: on valid&ready, capture colour_in and mark full; colour_ready = !full.
REQ-016 Active register drives comparisons; loaded from pending only at period wrap or on IDLE->RUN, then pending cleared.
REQ-017 Simultaneous valid&ready and pending->active transfer: impossible, since ready=0 when full; no bypass from colour_in to active.
REQ-018 pwm_x registered: next pwm_x = RUN & (step_cnt < duty_x); duty 0 -> always low, duty 255 -> always high.
REQ-019 Latency: pwm outputs reflect step_cnt one clk after it changes.
REQ-020 In IDLE: pre_cnt=0, step_cnt=0, pwm_*=0, period_done=0; pending and active retained; handshake still accepts.
REQ-021 sys_on dropped mid-period: outputs 0 on the next cycle; the period restarts from step 0 on re-enable.

Reset
REQ-022 rst_n low: state=IDLE, pre_cnt=0, step_cnt=0, pending=0 (empty), active=24'h000000, pwm_*=0, period_done=0, colour_ready=1.
REQ-023 Reset asserted mid-operation clears all state immediately, regardless of clk.

Configuration
REQ-024 Macro RGB_PWM_GAMMA_EN defined: duty_x = (c*c + 255) >> 8 per channel (0->0, 1->1, 128->64, 255->255).
REQ-025 RGB_PWM_GAMMA_EN undefined: duty_x = c (linear); no multiplier synthesized.

Structure
REQ-026 Package rgb_pkg holds: rgb_t struct (r,g,b bytes), PWM_STEPS=255, and the channel index constants.
REQ-027 Sub-module pwm_channel: one per colour, instantiated three times; contains the optional gamma map and the registered comparator.

Verification
REQ-028 Reset with PRESCALE=1 -> pwm_*=0, colour_ready=1, period_done=0.
REQ-029 Load 24'hFF8000, sys_on=1, PRESCALE=1 -> per 255-cycle period: pwm_r high 255, pwm_g high 128 (64 with GAMMA), pwm_b high 0; period_done pulse every 255 cycles.
REQ-030 Write 24'h00FF00 mid-period -> ready drops; old colour held until the wrap, new duty from next period; ready=1 after the wrap.
REQ-031 Second valid while full -> not accepted (ready=0); first value is the one applied.
REQ-032 PRESCALE=4, drop sys_on at step 100 -> pwm_* low next cycle; re-enable -> period restarts at step 0 with full 1020-cycle period.
REQ-033 Assert rst_n low mid-period asynchronously -> all outputs to reset values within the same cycle, pending lost.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB PWM driver: colour struct, step count,
// channel indices and the run-state encoding.
package rgb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int PWM_STEPS = 255;
  localparam int NUM_CH    = 3;
  localparam int CH_R      = 0;
  localparam int CH_G      = 1;
  localparam int CH_B      = 2;

  // Select one colour byte by channel index.
  function automatic logic [7:0] chan_byte(input rgb_t c, input int idx);
    logic [7:0] res;
    res = c.b;
    if (idx == CH_R) res = c.r;
    else if (idx == CH_G) res = c.g;
    return res;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: optional gamma map (RGB_PWM_GAMMA_EN) feeding a registered
// step comparator. Duty 0 is always low, duty 255 always high.
module pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] colour,
  input  logic [7:0] step_cnt,
  input  logic       run,
  output logic       pwm
);

  logic [7:0] duty;
  logic       pwm_reg;
  logic       pwm_next;

`ifdef RGB_PWM_GAMMA_EN
  // Square law with round-up; 255*255+255 still fits in 16 bits.
  logic [15:0] sq;
  assign sq   = ({8'd0, colour} * {8'd0, colour}) + 16'd255;
  assign duty = sq[15:8];
`else
  assign duty = colour;
`endif

  assign pwm_next = run && (step_cnt < duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_reg <= 1'b0;
    end else begin
      pwm_reg <= pwm_next;
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB PWM driver with a one-deep colour pending slot that is
// promoted to the active colour only at period boundaries. Gamma: RGB_PWM_GAMMA_EN.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int STEPS    = PWM_STEPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] colour_in,
  input  logic        colour_valid,
  output logic        colour_ready,
  input  logic        sys_on,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_done
);

  localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);
  localparam logic [7:0]  STEP_MAX = 8'(STEPS - 1);

  state_t      state_reg, state_next;
  logic [15:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0]  step_cnt_reg, step_cnt_next;
  rgb_t        pending_reg, pending_next;
  logic        full_reg, full_next;
  rgb_t        active_reg, active_next;
  logic        period_done_reg, period_done_next;

  logic running;
  logic tick;
  logic wrap;
  logic start;
  logic accept;
  logic load;

  // Counting stops in the same cycle sys_on falls, so outputs drop on the next edge.
  assign running = (state_reg == ST_RUN) && sys_on;
  assign tick    = running && (pre_cnt_reg == PRE_MAX);
  assign wrap    = tick && (step_cnt_reg == STEP_MAX);
  assign start   = (state_reg == ST_IDLE) && sys_on;
  assign accept  = colour_valid && !full_reg;
  assign load    = (wrap || start) && full_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (sys_on) state_next = ST_RUN;
      ST_RUN:  if (!sys_on) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_next     = 16'd0;
    step_cnt_next    = 8'd0;
    period_done_next = wrap;
    if (running) begin
      pre_cnt_next  = tick ? 16'd0 : pre_cnt_reg + 16'd1;
      step_cnt_next = step_cnt_reg;
      if (tick) step_cnt_next = wrap ? 8'd0 : step_cnt_reg + 8'd1;
    end
  end

  // accept needs an empty slot and load needs a full one, so they never collide.
  always_comb begin
    pending_next = pending_reg;
    full_next    = full_reg;
    active_next  = active_reg;
    if (accept) begin
      pending_next = rgb_t'(colour_in);
      full_next    = 1'b1;
    end else if (load) begin
      active_next = pending_reg;
      full_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pre_cnt_reg     <= 16'd0;
      step_cnt_reg    <= 8'd0;
      pending_reg     <= '0;
      full_reg        <= 1'b0;
      active_reg      <= '0;
      period_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pre_cnt_reg     <= pre_cnt_next;
      step_cnt_reg    <= step_cnt_next;
      pending_reg     <= pending_next;
      full_reg        <= full_next;
      active_reg      <= active_next;
      period_done_reg <= period_done_next;
    end
  end

  logic [NUM_CH-1:0] pwm_vec;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_channel u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .colour   (chan_byte(active_reg, gi)),
        .step_cnt (step_cnt_reg),
        .run      (running),
        .pwm      (pwm_vec[gi])
      );
    end
  endgenerate

  assign pwm_r        = pwm_vec[CH_R];
  assign pwm_g        = pwm_vec[CH_G];
  assign pwm_b        = pwm_vec[CH_B];
  assign period_done  = period_done_reg;
  assign colour_ready = !full_reg;

endmodule
